// File: rtl/lru_way_select.sv
// lru_way_select: request-side controller for one 4-way L1 set.
// Resolves a tag lookup as hit or miss. On a miss it selects a victim way
// and runs a fill handshake bounded by FILL_TIMEOUT. Every completed request
// produces one LRU update pulse, and every request produces one response.
// Saturating hit and miss counters are kept.
//
// Optional feature: define LRU_WAYSEL_INVALID_FIRST_EN to prefer the
// lowest-index invalid way as the victim over the tracker's evict_way.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid / req_ready       lookup request handshake
//   hit_vec, valid_vec          per-way tag match / line valid, sampled on accept
//   evict_way                   LRU victim from the tracker, sampled on accept
//   access_way / access_valid   one-cycle MRU promotion strobe to the tracker
//   fill_req / fill_way / fill_ack  line-fill handshake with the next level
//   resp_valid / resp_hit / resp_way / resp_err / multi_hit  completion report
//   hit_cnt / miss_cnt          saturating statistics
module lru_way_select #(
    parameter int unsigned FILL_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       hit_vec,
    input  logic [3:0]       valid_vec,
    input  logic [1:0]       evict_way,
    output logic [1:0]       access_way,
    output logic             access_valid,
    output logic             fill_req,
    output logic [1:0]       fill_way,
    input  logic             fill_ack,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [1:0]       resp_way,
    output logic             resp_err,
    output logic             multi_hit,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    // Wide enough to hold FILL_TIMEOUT itself, which also covers FILL_TIMEOUT == 1.
    localparam int unsigned TMR_W = $clog2(FILL_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        UPDATE = 2'd2,
        ABORT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       way_q, way_d;
    logic             hit_q, hit_d;
    logic             multi_q, multi_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic req_ready_d, access_valid_d, fill_req_d, resp_valid_d;
    logic resp_hit_d, resp_err_d, multi_hit_d;

    logic       accept;
    logic       any_hit;
    logic       many_hits;
    logic [1:0] hit_way;
    logic [1:0] victim;

    // Index of the lowest set bit; only meaningful when v is non-zero.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Lookup decode on the incoming request.
    always_comb begin
        accept    = req_valid && req_ready;
        any_hit   = |hit_vec;
        // Clearing the lowest set bit leaves something only if two or more were set.
        many_hits = (hit_vec & (hit_vec - 4'd1)) != 4'd0;
        hit_way   = lowest_set(hit_vec);
    end

`ifdef LRU_WAYSEL_INVALID_FIRST_EN
    // Filling an empty way first avoids evicting live data.
    always_comb begin
        victim = (valid_vec != 4'hF) ? lowest_set(~valid_vec) : evict_way;
    end
`else
    logic unused_valid_vec;

    always_comb begin
        victim           = evict_way;
        unused_valid_vec = ^valid_vec;
    end
`endif

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        way_d      = way_q;
        hit_d      = hit_q;
        multi_d    = multi_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (any_hit) begin
                        way_d   = hit_way;
                        hit_d   = 1'b1;
                        multi_d = many_hits;
                        state_d = UPDATE;
                    end else begin
                        way_d   = victim;
                        hit_d   = 1'b0;
                        multi_d = 1'b0;
                        tmr_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                tmr_d = tmr_q + TMR_W'(1);
                // An ack on the final cycle still completes the fill.
                if (fill_ack) begin
                    state_d = UPDATE;
                end else if (tmr_q == TMR_W'(FILL_TIMEOUT - 1)) begin
                    state_d = ABORT;
                end
            end
            UPDATE: begin
                if (hit_q) hit_cnt_d  = sat_inc(hit_cnt_q);
                else       miss_cnt_d = sat_inc(miss_cnt_q);
                state_d = IDLE;
            end
            ABORT: begin
                miss_cnt_d = sat_inc(miss_cnt_q);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        req_ready_d    = (state_d == IDLE);
        access_valid_d = (state_d == UPDATE);
        fill_req_d     = (state_d == FILL);
        resp_valid_d   = (state_d == UPDATE) || (state_d == ABORT);
        resp_err_d     = (state_d == ABORT);
        resp_hit_d     = (state_d == UPDATE) && hit_d;
        multi_hit_d    = (state_d == UPDATE) && multi_d;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            way_q        <= 2'd0;
            hit_q        <= 1'b0;
            multi_q      <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            req_ready    <= 1'b0;
            access_valid <= 1'b0;
            fill_req     <= 1'b0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_hit     <= 1'b0;
            multi_hit    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            way_q        <= way_d;
            hit_q        <= hit_d;
            multi_q      <= multi_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            req_ready    <= req_ready_d;
            access_valid <= access_valid_d;
            fill_req     <= fill_req_d;
            resp_valid   <= resp_valid_d;
            resp_err     <= resp_err_d;
            resp_hit     <= resp_hit_d;
            multi_hit    <= multi_hit_d;
        end
    end

    // All way outputs present the registered way.
    assign access_way = way_q;
    assign fill_way   = way_q;
    assign resp_way   = way_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
